// File: rtl/imm_ext_pkg.sv
// Shared mode encodings and the reference-width immediate extender for the SEQ operand path.
package imm_ext_pkg;

    localparam int unsigned IMM_EXT_IMM_W  = 16;
    localparam int unsigned IMM_EXT_DATA_W = 32;
    localparam int unsigned IMM_EXT_FILL_W = IMM_EXT_DATA_W - IMM_EXT_IMM_W;

    typedef logic [1:0] imm_mode_t;

    localparam imm_mode_t IMM_ZEXT   = 2'b00;
    localparam imm_mode_t IMM_SEXT   = 2'b01;
    localparam imm_mode_t IMM_UPPER  = 2'b10;
    localparam imm_mode_t IMM_BRANCH = 2'b11;

    // BRANCH is the sign-extended value scaled by 4; the top two fill bits fall off.
    function automatic logic [IMM_EXT_DATA_W-1:0] imm_extend(
        input logic [IMM_EXT_IMM_W-1:0] imm,
        input imm_mode_t                mode
    );
        logic [IMM_EXT_DATA_W-1:0] sext;
        sext = {{IMM_EXT_FILL_W{imm[IMM_EXT_IMM_W-1]}}, imm};
        case (mode)
            IMM_ZEXT:  imm_extend = {{IMM_EXT_FILL_W{1'b0}}, imm};
            IMM_SEXT:  imm_extend = sext;
            IMM_UPPER: imm_extend = {imm, {IMM_EXT_FILL_W{1'b0}}};
            default:   imm_extend = {sext[IMM_EXT_DATA_W-3:0], 2'b00};
        endcase
    endfunction

endpackage

// File: rtl/imm_ext_fifo.sv
// In-order circular output buffer with registered head data and valid.
module imm_ext_fifo #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [$clog2(DEPTH):0]   out_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              push_c;
    logic              pop_c;

    // Space is judged on stored state only, and never while reset is asserted.
    assign in_ready  = ~rst & (count_q < CNT_W'(DEPTH));
    assign push_c    = in_valid & in_ready;
    assign pop_c     = out_valid_q & out_ready;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_count = count_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push_c) begin
            mem_d[wr_ptr_q] = in_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({push_c, pop_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // Head is pre-computed so the outputs come straight from flops; empty forces zero.
        out_valid_d = (count_d != '0);
        out_data_d  = out_valid_d ? mem_d[rd_ptr_d] : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    // Storage needs no reset: entries are only observed through valid pointers.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/imm_extend_pipe.sv
// Registered immediate-extension stage between decode and the ALU operand mux.
module imm_extend_pipe
    import imm_ext_pkg::*;
#(
    parameter int unsigned IMM_W  = 16,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [IMM_W-1:0]         in_imm,
    input  logic [1:0]               in_mode,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [$clog2(DEPTH):0]   out_count
);

    localparam int unsigned FILL_W = DATA_W - IMM_W;

    logic [DATA_W-1:0] ext_data_c;

    // The package extender covers the reference widths; other widths use the same rules inline.
    if (IMM_W == IMM_EXT_IMM_W && DATA_W == IMM_EXT_DATA_W) begin : g_pkg_ext
        assign ext_data_c = imm_extend(in_imm, in_mode);
    end else begin : g_gen_ext
        logic [DATA_W-1:0] sext_c;
        always_comb begin
            sext_c = {{FILL_W{in_imm[IMM_W-1]}}, in_imm};
            case (in_mode)
                IMM_ZEXT:  ext_data_c = {{FILL_W{1'b0}}, in_imm};
                IMM_SEXT:  ext_data_c = sext_c;
                IMM_UPPER: ext_data_c = {in_imm, {FILL_W{1'b0}}};
                default:   ext_data_c = {sext_c[DATA_W-3:0], 2'b00};
            endcase
        end
    end

    imm_ext_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (ext_data_c),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count)
    );

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Scoreboard bench for imm_extend_pipe at IMM_W=16, DATA_W=32, DEPTH=2.
module tb_imm_extend_pipe;

    localparam int unsigned IMM_W  = 16;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEPTH  = 2;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [IMM_W-1:0]  in_imm;
    logic [1:0]        in_mode;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        out_count;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DATA_W-1:0] exp_q [$];
    logic [DATA_W-1:0] got_q [$];

    imm_extend_pipe #(
        .IMM_W  (IMM_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_imm    (in_imm),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] model(input logic [15:0] imm, input logic [1:0] mode);
        logic signed [31:0] s;
        s = $signed(imm);
        case (mode)
            2'd0:    model = 32'(imm);
            2'd1:    model = s;
            2'd2:    model = 32'(imm) * 32'h0001_0000;
            default: model = 32'(s * 4);
        endcase
    endfunction

    // Records handshakes seen just before the edge, then advances one clock.
    task automatic step();
        #1;
        if (rst) begin
            exp_q.delete();
            got_q.delete();
        end else begin
            if (in_valid && in_ready) exp_q.push_back(model(in_imm, in_mode));
            if (out_valid && out_ready) got_q.push_back(out_data);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; in_imm = 16'hABCD; in_mode = 2'd0; out_ready = 1'b0;
        #1;
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready_hi: got %b expected 0", in_ready); end
        step();
        step();
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready_hold: got %b expected 0", in_ready); end
        rst = 1'b0; in_valid = 1'b0;
        #1;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_tests++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
        n_tests++; if (out_count !== 2'd0) begin n_fail++; $display("FAIL reset_out_count: got %0d expected 0", out_count); end
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready_after: got %b expected 1", in_ready); end
    endtask

    task automatic test_modes();
        logic [15:0] imms [6];
        logic [1:0]  modes [6];
        logic [31:0] exps [6];
        logic [31:0] g, e;
        imms  = '{16'h8001, 16'h8001, 16'h7FFF, 16'h1234, 16'hFFFF, 16'h0004};
        modes = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd3, 2'd3};
        exps  = '{32'h0000_8001, 32'hFFFF_8001, 32'h0000_7FFF, 32'h1234_0000, 32'hFFFF_FFFC, 32'h0000_0010};
        for (int i = 0; i < 6; i++) begin
            in_imm = imms[i]; in_mode = modes[i]; in_valid = 1'b1; out_ready = 1'b1;
            step();
            in_valid = 1'b0;
            n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL mode%0d_valid: got %b expected 1", i, out_valid); end
            n_tests++; if (out_data !== exps[i]) begin n_fail++; $display("FAIL mode%0d_data: got %h expected %h", i, out_data, exps[i]); end
            n_tests++; if (out_count !== 2'd1) begin n_fail++; $display("FAIL mode%0d_count: got %0d expected 1", i, out_count); end
            step();
            n_tests++; if (out_valid !== 1'b0 || out_data !== 32'h0) begin
                n_fail++; $display("FAIL mode%0d_empty: got valid=%b data=%h expected valid=0 data=0", i, out_valid, out_data);
            end
        end
        n_tests++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL modes_sb_size: got %0d expected %0d", got_q.size(), exp_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            n_tests++; if (g !== e) begin n_fail++; $display("FAIL modes_sb: got %h expected %h", g, e); end
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_back_to_back();
        logic [31:0] g, e;
        out_ready = 1'b1; in_valid = 1'b1; in_mode = 2'd1; in_imm = 16'h8001;
        step();
        n_tests++; if (out_data !== 32'hFFFF_8001) begin n_fail++; $display("FAIL b2b_first: got %h expected ffff8001", out_data); end
        in_imm = 16'h7FFF;
        step();
        in_valid = 1'b0;
        n_tests++; if (out_data !== 32'h0000_7FFF) begin n_fail++; $display("FAIL b2b_second: got %h expected 00007fff", out_data); end
        n_tests++; if (out_count !== 2'd1) begin n_fail++; $display("FAIL b2b_count: got %0d expected 1", out_count); end
        step();
        n_tests++; if (got_q.size() != 2) begin n_fail++; $display("FAIL b2b_sb_size: got %0d expected 2", got_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            n_tests++; if (g !== e) begin n_fail++; $display("FAIL b2b_sb: got %h expected %h", g, e); end
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_random_stream();
        int sent = 0;
        int cyc = 0;
        logic acc = 1'b1;
        logic held;
        logic [31:0] hold_data, g, e;
        in_valid = 1'b0;
        while ((sent < 40 || out_count != 2'd0) && cyc < 600) begin
            if (!in_valid || acc) begin
                in_valid = (sent < 40) && ($urandom_range(0, 3) != 0);
                in_imm   = 16'($urandom);
                in_mode  = 2'($urandom);
            end
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            acc       = in_valid && in_ready;
            held      = out_valid && !out_ready;
            hold_data = out_data;
            step();
            cyc++;
            if (acc) sent++;
            if (held) begin
                n_tests++; if (out_valid !== 1'b1 || out_data !== hold_data) begin
                    n_fail++; $display("FAIL rand_hold: got valid=%b data=%h expected valid=1 data=%h", out_valid, out_data, hold_data);
                end
            end
        end
        in_valid = 1'b0;
        n_tests++; if (cyc >= 600) begin n_fail++; $display("FAIL rand_timeout: got %0d cycles expected < 600", cyc); end
        n_tests++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rand_sb_size: got %0d expected %0d", got_q.size(), exp_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            n_tests++; if (g !== e) begin n_fail++; $display("FAIL rand_sb: got %h expected %h", g, e); end
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_backpressure();
        logic [31:0] g, e;
        logic [31:0] order [3];
        order = '{32'h0000_000A, 32'h0000_000B, 32'h0000_000C};
        out_ready = 1'b0; in_valid = 1'b1; in_mode = 2'd0; in_imm = 16'h000A;
        step();
        n_tests++; if (out_count !== 2'd1 || out_data !== 32'hA) begin n_fail++; $display("FAIL bp_push_a: got count=%0d data=%h expected count=1 data=a", out_count, out_data); end
        in_imm = 16'h000B;
        step();
        n_tests++; if (out_count !== 2'd2 || out_data !== 32'hA) begin n_fail++; $display("FAIL bp_push_b: got count=%0d data=%h expected count=2 data=a", out_count, out_data); end
        in_imm = 16'h000C;
        #1;
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_ready: got %b expected 0", in_ready); end
        for (int i = 0; i < 2; i++) begin
            step();
            n_tests++; if (out_count !== 2'd2 || out_data !== 32'hA || in_ready !== 1'b0) begin
                n_fail++; $display("FAIL bp_hold: got count=%0d data=%h ready=%b expected count=2 data=a ready=0", out_count, out_data, in_ready);
            end
        end
        out_ready = 1'b1;
        step();
        n_tests++; if (out_count !== 2'd1 || out_data !== 32'hB || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL bp_pop_a: got count=%0d data=%h ready=%b expected count=1 data=b ready=1", out_count, out_data, in_ready);
        end
        step();
        in_valid = 1'b0;
        n_tests++; if (out_count !== 2'd1 || out_data !== 32'hC) begin n_fail++; $display("FAIL bp_pop_b: got count=%0d data=%h expected count=1 data=c", out_count, out_data); end
        step();
        n_tests++; if (out_count !== 2'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drained: got count=%0d valid=%b expected count=0 valid=0", out_count, out_valid); end
        n_tests++; if (got_q.size() != 3) begin n_fail++; $display("FAIL bp_sb_size: got %0d expected 3", got_q.size()); end
        for (int i = 0; i < 3 && got_q.size() > 0 && exp_q.size() > 0; i++) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            n_tests++; if (g !== e || g !== order[i]) begin n_fail++; $display("FAIL bp_sb: got %h expected %h", g, order[i]); end
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_push_pop();
        logic [31:0] g, e;
        out_ready = 1'b0; in_valid = 1'b1; in_mode = 2'd1; in_imm = 16'hF00D;
        step();
        n_tests++; if (out_count !== 2'd1) begin n_fail++; $display("FAIL pp_fill: got %0d expected 1", out_count); end
        out_ready = 1'b1; in_mode = 2'd2; in_imm = 16'h1111;
        step();
        n_tests++; if (out_count !== 2'd1 || out_data !== 32'h1111_0000) begin n_fail++; $display("FAIL pp_first: got count=%0d data=%h expected count=1 data=11110000", out_count, out_data); end
        in_mode = 2'd3; in_imm = 16'h0001;
        step();
        n_tests++; if (out_count !== 2'd1 || out_data !== 32'h0000_0004) begin n_fail++; $display("FAIL pp_second: got count=%0d data=%h expected count=1 data=00000004", out_count, out_data); end
        in_valid = 1'b0;
        step();
        n_tests++; if (out_count !== 2'd0) begin n_fail++; $display("FAIL pp_drain: got %0d expected 0", out_count); end
        n_tests++; if (got_q.size() != 3) begin n_fail++; $display("FAIL pp_sb_size: got %0d expected 3", got_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            n_tests++; if (g !== e) begin n_fail++; $display("FAIL pp_sb: got %h expected %h", g, e); end
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_reset_mid();
        logic [31:0] g, e;
        out_ready = 1'b0; in_valid = 1'b1; in_mode = 2'd0; in_imm = 16'h0005;
        step();
        in_imm = 16'h0006;
        step();
        n_tests++; if (out_count !== 2'd2) begin n_fail++; $display("FAIL rm_full: got %0d expected 2", out_count); end
        rst = 1'b1; in_imm = 16'h0007;
        #1;
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rm_ready_in_rst: got %b expected 0", in_ready); end
        step();
        rst = 1'b0; in_valid = 1'b0;
        #1;
        n_tests++; if (out_valid !== 1'b0 || out_data !== 32'h0 || out_count !== 2'd0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL rm_after: got valid=%b data=%h count=%0d ready=%b expected 0 0 0 1", out_valid, out_data, out_count, in_ready);
        end
        out_ready = 1'b1; in_valid = 1'b1; in_imm = 16'h0009;
        step();
        in_valid = 1'b0;
        n_tests++; if (out_data !== 32'h9 || out_count !== 2'd1) begin n_fail++; $display("FAIL rm_fresh: got count=%0d data=%h expected count=1 data=9", out_count, out_data); end
        step();
        n_tests++; if (got_q.size() != 1) begin n_fail++; $display("FAIL rm_sb_size: got %0d expected 1", got_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            n_tests++; if (g !== e) begin n_fail++; $display("FAIL rm_sb: got %h expected %h", g, e); end
        end
        exp_q.delete(); got_q.delete();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_imm = '0; in_mode = '0; out_ready = 1'b0;
        test_reset();
        test_modes();
        test_back_to_back();
        test_backpressure();
        test_push_pop();
        test_random_stream();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
